// File: rtl/pixel_array_readout_ctrl.sv
// rtl/pixel_array_readout_ctrl.sv - global-shutter pixel array sequencer and row readout streamer
//
// Purpose:
//   Runs one global-shutter frame per START: erase, expose, a shared 8-bit
//   ramp conversion, then reads the array one row at a time into a row
//   buffer and streams the pixels out over a valid/ready interface.
//
// Ports:
//   CLK, RESET     clock (rising edge) and synchronous active-high reset
//   START          frame request, sampled only while idle
//   ERASE          pixel erase strobe
//   EXPOSE         exposure window
//   RAMP           conversion ramp enable
//   COUNTER        conversion code broadcast to the array (0 outside conversion)
//   READ           one-hot row select
//   DATA_IN        row data from the array, DATA_IN[c] is column c
//   PIXEL_DATA     streamed pixel value
//   PIXEL_VALID    PIXEL_DATA valid
//   PIXEL_READY    sink ready; a transfer is VALID && READY at a rising edge
//   PIXEL_LAST     marks the final pixel of the frame
//   BUSY           high whenever a frame is in progress
//
// Build option:
//   READOUT_TEST_PATTERN_EN - row buffer loads {row[3:0], col[3:0]} instead of
//   DATA_IN; strobe timing is unchanged.

module pixel_array_readout_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int ERASE_CYCLES       = 5,
  parameter int EXPOSE_CYCLES      = 255,
  parameter int READ_CYCLES        = 2
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                START,
  output logic                                ERASE,
  output logic                                EXPOSE,
  output logic                                RAMP,
  output logic [7:0]                          COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]       READ,
  input  logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   DATA_IN,
  output logic [7:0]                          PIXEL_DATA,
  output logic                                PIXEL_VALID,
  input  logic                                PIXEL_READY,
  output logic                                PIXEL_LAST,
  output logic                                BUSY
);

  localparam int W     = PIXEL_ARRAY_WIDTH;
  localparam int H     = PIXEL_ARRAY_HEIGHT;
  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;

  // Phase counter covers the longest timed phase; conversion needs 256 steps.
  localparam int MAX_A     = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_B     = (MAX_A > READ_CYCLES) ? MAX_A : READ_CYCLES;
  localparam int PHASE_MAX = (MAX_B > 256) ? MAX_B : 256;
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  localparam logic [COL_W-1:0]   LAST_COL    = COL_W'(W - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(H - 1);
  localparam logic [PHASE_W-1:0] ERASE_LAST  = PHASE_W'(ERASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] EXPOSE_LAST = PHASE_W'(EXPOSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] READ_LAST   = PHASE_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE_S,
    EXPOSE_S,
    CONVERT,
    READ_S,
    STREAM
  } state_t;

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [W-1:0][7:0]    row_buf;
  logic [W-1:0][7:0]    capture_data;
  logic [COL_W-1:0]     col_nxt;
  logic [ROW_W-1:0]     row_nxt;

  assign col_nxt = col + 1'b1;
  assign row_nxt = row + 1'b1;

  // What the row buffer loads at the end of the READ window.
  always_comb begin
    capture_data = '0;
    for (int c = 0; c < W; c++) begin
`ifdef READOUT_TEST_PATTERN_EN
      capture_data[c] = {4'(row), 4'(c)};
`else
      capture_data[c] = DATA_IN[c];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      phase       <= '0;
      col         <= '0;
      row         <= '0;
      row_buf     <= '0;
      ERASE       <= 1'b0;
      EXPOSE      <= 1'b0;
      RAMP        <= 1'b0;
      COUNTER     <= 8'd0;
      READ        <= '0;
      PIXEL_DATA  <= 8'd0;
      PIXEL_VALID <= 1'b0;
      PIXEL_LAST  <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state <= ERASE_S;
            ERASE <= 1'b1;
            BUSY  <= 1'b1;
            phase <= '0;
            row   <= '0;
            col   <= '0;
          end
        end

        ERASE_S: begin
          if (phase == ERASE_LAST) begin
            ERASE  <= 1'b0;
            EXPOSE <= 1'b1;
            phase  <= '0;
            state  <= EXPOSE_S;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        EXPOSE_S: begin
          if (phase == EXPOSE_LAST) begin
            EXPOSE  <= 1'b0;
            RAMP    <= 1'b1;
            COUNTER <= 8'd0;
            phase   <= '0;
            state   <= CONVERT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // COUNTER itself sequences the 256 conversion steps.
        CONVERT: begin
          if (COUNTER == 8'hFF) begin
            RAMP    <= 1'b0;
            COUNTER <= 8'd0;
            READ    <= H'(1) << row;
            phase   <= '0;
            state   <= READ_S;
          end else begin
            COUNTER <= COUNTER + 8'd1;
          end
        end

        // Capture on the edge that ends the last READ cycle and present
        // column 0 straight away so VALID rises in the first STREAM cycle.
        READ_S: begin
          if (phase == READ_LAST) begin
            READ        <= '0;
            row_buf     <= capture_data;
            PIXEL_DATA  <= capture_data[0];
            PIXEL_VALID <= 1'b1;
            PIXEL_LAST  <= (row == LAST_ROW) && (LAST_COL == '0);
            col         <= '0;
            state       <= STREAM;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // Data/LAST only change on a transfer, so they hold under backpressure.
        STREAM: begin
          if (PIXEL_VALID && PIXEL_READY) begin
            if (col == LAST_COL) begin
              PIXEL_VALID <= 1'b0;
              PIXEL_LAST  <= 1'b0;
              PIXEL_DATA  <= 8'd0;
              col         <= '0;
              phase       <= '0;
              if (row == LAST_ROW) begin
                row   <= '0;
                BUSY  <= 1'b0;
                state <= IDLE;
              end else begin
                row   <= row_nxt;
                READ  <= H'(1) << row_nxt;
                state <= READ_S;
              end
            end else begin
              col        <= col_nxt;
              PIXEL_DATA <= row_buf[col_nxt];
              PIXEL_LAST <= (row == LAST_ROW) && (col_nxt == LAST_COL);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_readout_ctrl.sv
// tb/tb_pixel_array_readout_ctrl.sv - directed self-checking bench for pixel_array_readout_ctrl

module tb_pixel_array_readout_ctrl;

  localparam int W = 2;
  localparam int H = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              START;
  logic              ERASE;
  logic              EXPOSE;
  logic              RAMP;
  logic [7:0]        COUNTER;
  logic [H-1:0]      READ;
  logic [W-1:0][7:0] DATA_IN;
  logic [7:0]        PIXEL_DATA;
  logic              PIXEL_VALID;
  logic              PIXEL_READY;
  logic              PIXEL_LAST;
  logic              BUSY;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  logic [7:0] got_data [16];
  logic       got_last [16];
  int         got_n;
  logic       stall_seen;
  logic       stall_ok;
  logic [7:0] exp_px [4];

  pixel_array_readout_ctrl #(
    .PIXEL_ARRAY_WIDTH (W),
    .PIXEL_ARRAY_HEIGHT(H),
    .ERASE_CYCLES      (5),
    .EXPOSE_CYCLES     (10),
    .READ_CYCLES       (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .ERASE      (ERASE),
    .EXPOSE     (EXPOSE),
    .RAMP       (RAMP),
    .COUNTER    (COUNTER),
    .READ       (READ),
    .DATA_IN    (DATA_IN),
    .PIXEL_DATA (PIXEL_DATA),
    .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_READY(PIXEL_READY),
    .PIXEL_LAST (PIXEL_LAST),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Pixel array model: row data appears while its READ line is high.
  always_comb begin
    case (READ)
      2'b01:   DATA_IN = {8'h34, 8'h12};
      2'b10:   DATA_IN = {8'h78, 8'h56};
      default: DATA_IN = 16'hC3A5;
    endcase
  end

  always @(negedge CLK) begin
    if (!RESET && ($countones({ERASE, EXPOSE, RAMP, |READ}) > 1))
      excl_viol++;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs until BUSY drops, recording every transfer. With bp set, READY is
  // held low for 3 cycles when the second pixel first becomes valid.
  task automatic collect(input bit bp);
    int         guard;
    bit         bp_done;
    logic [7:0] held_data;
    logic       held_last;
    got_n      = 0;
    guard      = 0;
    bp_done    = 1'b0;
    stall_seen = 1'b0;
    stall_ok   = 1'b1;
    while (BUSY === 1'b1 && guard < 2000) begin
      if (bp && !bp_done && PIXEL_VALID === 1'b1 && got_n == 1) begin
        stall_seen  = 1'b1;
        PIXEL_READY = 1'b0;
        held_data   = PIXEL_DATA;
        held_last   = PIXEL_LAST;
        repeat (3) begin
          tick();
          if (PIXEL_VALID !== 1'b1 || PIXEL_DATA !== held_data || PIXEL_LAST !== held_last)
            stall_ok = 1'b0;
        end
        PIXEL_READY = 1'b1;
        bp_done     = 1'b1;
      end
      if (PIXEL_VALID === 1'b1 && PIXEL_READY === 1'b1) begin
        if (got_n < 16) begin
          got_data[got_n] = PIXEL_DATA;
          got_last[got_n] = PIXEL_LAST;
        end
        got_n++;
        if (PIXEL_LAST === 1'b1) begin
          tick();
          chk("busy_fall_after_last", {31'd0, BUSY}, 32'd0);
          guard++;
          continue;
        end
      end
      tick();
      guard++;
    end
    chk("frame_within_budget", {31'd0, guard < 2000}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk($sformatf("%s_count", tag), got_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_px%0d", tag, i), {24'd0, got_data[i]}, {24'd0, exp_px[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, {31'd0, i == 3});
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ramp_ok;
    bit  busy_seen;

`ifdef READOUT_TEST_PATTERN_EN
    exp_px[0] = 8'h00; exp_px[1] = 8'h01; exp_px[2] = 8'h10; exp_px[3] = 8'h11;
`else
    exp_px[0] = 8'h12; exp_px[1] = 8'h34; exp_px[2] = 8'h56; exp_px[3] = 8'h78;
`endif

    RESET       = 1'b1;
    START       = 1'b0;
    PIXEL_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    chk("reset_outputs",
        {ERASE, EXPOSE, RAMP, COUNTER, READ, PIXEL_DATA, PIXEL_VALID, PIXEL_LAST, BUSY}, 32'd0);
    tick();
    chk("idle_no_start_busy", {31'd0, BUSY}, 32'd0);

    // 1. Strobe timing and first full frame
    pulse_start();
    chk("t1_busy_rise", {31'd0, BUSY}, 32'd1);
    n = 0;
    while (ERASE === 1'b1 && n < 600) begin n++; tick(); end
    chk("t1_erase_cycles", n, 32'd5);
    chk("t1_expose_follows", {31'd0, EXPOSE}, 32'd1);
    n = 0;
    while (EXPOSE === 1'b1 && n < 600) begin n++; tick(); end
    chk("t1_expose_cycles", n, 32'd10);
    chk("t1_ramp_follows", {31'd0, RAMP}, 32'd1);
    ramp_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (RAMP !== 1'b1 || COUNTER !== 8'(i)) ramp_ok = 1'b0;
      tick();
    end
    chk("t1_ramp_sequence", {31'd0, ramp_ok}, 32'd1);
    chk("t1_ramp_end", {23'd0, RAMP, COUNTER}, 32'd0);
    chk("t1_read_row0", {30'd0, READ}, 32'd1);
    n = 0;
    while (READ === 2'b01 && n < 600) begin n++; tick(); end
    chk("t1_read_cycles", n, 32'd2);
    chk("t1_valid_first_stream", {31'd0, PIXEL_VALID}, 32'd1);

    // 2. Full frame with READY held high
    collect(1'b0);
    check_frame("t2");

    // 3. Back-to-back frame with backpressure on the second pixel
    pulse_start();
    chk("t3_b2b_start", {31'd0, ERASE}, 32'd1);
    collect(1'b1);
    chk("t3_stall_seen", {31'd0, stall_seen}, 32'd1);
    chk("t3_stall_stable", {31'd0, stall_ok}, 32'd1);
    check_frame("t3");

    // 4. Reset in the 4th EXPOSE cycle, then a clean frame
    tick();
    pulse_start();
    repeat (5) tick();
    chk("t4_expose_reached", {31'd0, EXPOSE}, 32'd1);
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t4_reset_outputs",
        {ERASE, EXPOSE, RAMP, COUNTER, READ, PIXEL_DATA, PIXEL_VALID, PIXEL_LAST, BUSY}, 32'd0);
    busy_seen = 1'b0;
    repeat (10) begin
      tick();
      if (BUSY !== 1'b0 || PIXEL_VALID !== 1'b0) busy_seen = 1'b1;
    end
    chk("t4_aborted_stays_idle", {31'd0, busy_seen}, 32'd0);
    pulse_start();
    collect(1'b0);
    check_frame("t4");

    // 5. START during CONVERT is ignored and not queued
    tick();
    pulse_start();
    n = 0;
    while (RAMP !== 1'b1 && n < 600) begin n++; tick(); end
    chk("t5_ramp_reached", {31'd0, RAMP}, 32'd1);
    repeat (100) tick();
    pulse_start();
    collect(1'b0);
    check_frame("t5");
    busy_seen = 1'b0;
    repeat (20) begin
      if (BUSY !== 1'b0 || ERASE !== 1'b0) busy_seen = 1'b1;
      tick();
    end
    chk("t5_start_not_queued", {31'd0, busy_seen}, 32'd0);

    chk("strobes_exclusive", excl_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
